// File: rtl/hc_symbol_hist_pkg.sv
// Shared Huffman-coding package.
// Symbol alphabet bounds, lane widths shared with the descending-sort stage,
// and the histogram state encoding.
package hc_symbol_hist_pkg;

    localparam int SYM_MIN = 1;
    localparam int SYM_MAX = 6;
    localparam int NUM_SYM = 6;
    localparam int DAT_W   = 8;
    localparam int TAG_W   = 3;

    typedef enum logic {
        COUNT = 1'b0,
        HOLD  = 1'b1
    } hist_state_e;

    // True when d is a gray level the histogram counts.
    function automatic logic sym_legal(input logic [DAT_W-1:0] d);
        return (d >= DAT_W'(SYM_MIN)) && (d <= DAT_W'(SYM_MAX));
    endfunction

endpackage

// File: rtl/hc_symbol_hist.sv
// Symbol histogram: counts occurrences of gray levels 1..6 over NUM_SAMPLES
// legal samples, then holds the six counts (with fixed tags 1..6) until the
// consumer acknowledges, clears, and starts the next frame.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   gray_valid/gray_data  input symbol stream; gray_ready high while counting
//   hist_valid/hist_ready completed frame handshake toward the sort stage
//   cnt1..cnt6            saturating occurrence counts for symbols 1..6
//   sym1..sym6            constant lane tags 1..6
//   err_sym               sticky: an illegal symbol arrived in this frame
module hc_symbol_hist
    import hc_symbol_hist_pkg::*;
#(
    parameter int NUM_SAMPLES = 100,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gray_valid,
    input  logic [DAT_W-1:0] gray_data,
    output logic             gray_ready,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    output logic [CNT_W-1:0] cnt4,
    output logic [CNT_W-1:0] cnt5,
    output logic [CNT_W-1:0] cnt6,
    output logic [TAG_W-1:0] sym1,
    output logic [TAG_W-1:0] sym2,
    output logic [TAG_W-1:0] sym3,
    output logic [TAG_W-1:0] sym4,
    output logic [TAG_W-1:0] sym5,
    output logic [TAG_W-1:0] sym6,
    output logic             err_sym
);

    hist_state_e state_q, state_d;
    logic [7:0]  smp_q;
    logic [NUM_SYM-1:0][CNT_W-1:0] cnt_q;
    logic        accept, legal, take, last, clr;

    // Both handshake outputs decode the state register directly, so they
    // are glitch-free registered signals.
    assign gray_ready = (state_q == COUNT);
    assign hist_valid = (state_q == HOLD);

    assign accept = gray_valid && gray_ready;
    assign legal  = sym_legal(gray_data);
    assign take   = accept && legal;
    // Illegal symbols do not advance the sample counter, so only a legal
    // accept can close the frame.
    assign last   = take && (smp_q == 8'(NUM_SAMPLES - 1));
    assign clr    = hist_valid && hist_ready;

    for (genvar k = 0; k < NUM_SYM; k++) begin : g_lane
        logic             inc;
        logic [CNT_W-1:0] cnt_r;

        assign inc = take && (gray_data == DAT_W'(k + 1));

        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                cnt_r <= '0;
            else if (clr)
                cnt_r <= '0;
            else if (inc && (cnt_r != {CNT_W{1'b1}}))
                cnt_r <= cnt_r + CNT_W'(1);
        end

        assign cnt_q[k] = cnt_r;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= COUNT;
            smp_q   <= '0;
            err_sym <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                smp_q   <= '0;
                err_sym <= 1'b0;
            end else begin
                if (take)
                    smp_q <= smp_q + 8'd1;
                if (accept && !legal)
                    err_sym <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COUNT:   if (last)       state_d = HOLD;
            HOLD:    if (hist_ready) state_d = COUNT;
            default: state_d = COUNT;
        endcase
    end

    assign cnt1 = cnt_q[0];
    assign cnt2 = cnt_q[1];
    assign cnt3 = cnt_q[2];
    assign cnt4 = cnt_q[3];
    assign cnt5 = cnt_q[4];
    assign cnt6 = cnt_q[5];

    assign sym1 = TAG_W'(1);
    assign sym2 = TAG_W'(2);
    assign sym3 = TAG_W'(3);
    assign sym4 = TAG_W'(4);
    assign sym5 = TAG_W'(5);
    assign sym6 = TAG_W'(6);

endmodule

// File: tb/tb_hc_symbol_hist.sv
// Directed bench for hc_symbol_hist. Five instances with different frame
// sizes / count widths, each driven independently:
//   0: NUM_SAMPLES=6   uniform frame, hold, back-to-back frames
//   1: NUM_SAMPLES=100 skewed frame with random gaps
//   2: NUM_SAMPLES=4   illegal symbols
//   3: NUM_SAMPLES=10  asynchronous reset mid-frame
//   4: NUM_SAMPLES=20, CNT_W=4 saturation
module tb_hc_symbol_hist;

    logic       clk;
    logic       gv [5];
    logic [7:0] gd [5];
    logic       hr [5];
    logic       rs [5];
    logic       gr [5];
    logic       hv [5];
    logic       er [5];
    logic [7:0] c  [5][6];
    logic [2:0] sy [5][6];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int W = (g == 4) ? 4 : 8;
        localparam int N = (g == 0) ? 6 : (g == 1) ? 100 : (g == 2) ? 4 :
                           (g == 3) ? 10 : 20;
        logic [W-1:0] o1, o2, o3, o4, o5, o6;

        hc_symbol_hist #(.NUM_SAMPLES(N), .CNT_W(W)) u_dut (
            .clk        (clk),
            .reset      (rs[g]),
            .gray_valid (gv[g]),
            .gray_data  (gd[g]),
            .gray_ready (gr[g]),
            .hist_valid (hv[g]),
            .hist_ready (hr[g]),
            .cnt1       (o1),
            .cnt2       (o2),
            .cnt3       (o3),
            .cnt4       (o4),
            .cnt5       (o5),
            .cnt6       (o6),
            .sym1       (sy[g][0]),
            .sym2       (sy[g][1]),
            .sym3       (sy[g][2]),
            .sym4       (sy[g][3]),
            .sym5       (sy[g][4]),
            .sym6       (sy[g][5]),
            .err_sym    (er[g])
        );

        assign c[g][0] = 8'(o1);
        assign c[g][1] = 8'(o2);
        assign c[g][2] = 8'(o3);
        assign c[g][3] = 8'(o4);
        assign c[g][4] = 8'(o5);
        assign c[g][5] = 8'(o6);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Check all six counts of instance i against e1..e6.
    task automatic chk_cnt(input string tag, input int i,
                           input int e1, input int e2, input int e3,
                           input int e4, input int e5, input int e6);
        chk({tag, ".cnt1"}, int'(c[i][0]), e1);
        chk({tag, ".cnt2"}, int'(c[i][1]), e2);
        chk({tag, ".cnt3"}, int'(c[i][2]), e3);
        chk({tag, ".cnt4"}, int'(c[i][3]), e4);
        chk({tag, ".cnt5"}, int'(c[i][4]), e5);
        chk({tag, ".cnt6"}, int'(c[i][5]), e6);
    endtask

    task automatic clk1;
        @(posedge clk);
        #1;
    endtask

    // Present one sample and wait (bounded) until it is accepted.
    task automatic send(input int i, input int s);
        int n = 0;
        gv[i] = 1'b1;
        gd[i] = 8'(s);
        while (!gr[i] && n < 50) begin
            clk1();
            n++;
        end
        chk("send_timeout", int'(n < 50), 1);
        clk1();
        gv[i] = 1'b0;
    endtask

    initial begin
        int seq [100];
        int tmp, j, sum;

        for (int i = 0; i < 5; i++) begin
            gv[i] = 1'b0; gd[i] = 8'd0; hr[i] = 1'b0; rs[i] = 1'b1;
        end
        #12;
        // Tags are constant even under reset.
        for (int k = 0; k < 6; k++) chk("reset.sym", int'(sy[0][k]), k + 1);
        chk("reset.hv", int'(hv[0]), 0);
        chk("reset.gr", int'(gr[0]), 1);
        chk("reset.err", int'(er[0]), 0);
        chk_cnt("reset", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) rs[i] = 1'b0;
        clk1();

        // ---- uniform frame
        for (int s = 1; s <= 6; s++) begin
            if (s == 6) chk("uni.hv_early", int'(hv[0]), 0);
            send(0, s);
        end
        chk("uni.hv", int'(hv[0]), 1);
        chk("uni.gr", int'(gr[0]), 0);
        chk_cnt("uni", 0, 1, 1, 1, 1, 1, 1);
        for (int k = 0; k < 6; k++) chk("uni.sym", int'(sy[0][k]), k + 1);
        gv[0] = 1'b1; gd[0] = 8'd3;         // must be ignored while holding
        repeat (10) clk1();
        chk("uni.hold_hv", int'(hv[0]), 1);
        chk_cnt("uni.hold", 0, 1, 1, 1, 1, 1, 1);
        gv[0] = 1'b0;
        hr[0] = 1'b1;
        clk1();
        chk("uni.ack_hv", int'(hv[0]), 0);
        chk("uni.ack_gr", int'(gr[0]), 1);
        chk_cnt("uni.ack", 0, 0, 0, 0, 0, 0, 0);

        // ---- back-to-back frames, hist_ready held high
        for (int k = 0; k < 6; k++) send(0, 4);
        chk("b2b.f1_hv", int'(hv[0]), 1);
        chk_cnt("b2b.f1", 0, 0, 0, 0, 6, 0, 0);
        gv[0] = 1'b1; gd[0] = 8'd1;
        clk1();                              // HOLD->COUNT edge: not accepted
        chk("b2b.pulse_hv", int'(hv[0]), 0);
        chk("b2b.gr", int'(gr[0]), 1);
        chk_cnt("b2b.edge", 0, 0, 0, 0, 0, 0, 0);
        clk1();                              // first accept of frame 2
        chk("b2b.first", int'(c[0][0]), 1);
        for (int k = 0; k < 5; k++) send(0, 1);
        chk("b2b.f2_hv", int'(hv[0]), 1);
        chk_cnt("b2b.f2", 0, 6, 0, 0, 0, 0, 0);
        clk1();
        chk("b2b.f2_pulse", int'(hv[0]), 0);
        hr[0] = 1'b0;

        // ---- skewed frame, random order and gaps
        for (int k = 0; k < 100; k++)
            seq[k] = (k < 40) ? 3 : (k < 70) ? 1 : (k < 90) ? 6 : 2;
        for (int k = 99; k > 0; k--) begin
            j = int'($urandom_range(0, k));
            tmp = seq[k]; seq[k] = seq[j]; seq[j] = tmp;
        end
        for (int k = 0; k < 100; k++) begin
            repeat ($urandom_range(0, 2)) clk1();
            if (k == 99) chk("skew.hv_early", int'(hv[1]), 0);
            send(1, seq[k]);
        end
        chk("skew.hv", int'(hv[1]), 1);
        chk_cnt("skew", 1, 30, 10, 40, 0, 0, 20);
        sum = 0;
        for (int k = 0; k < 6; k++) sum += int'(c[1][k]);
        chk("skew.sum", sum, 100);

        // ---- illegal symbols
        send(2, 1);
        chk("ill.err0", int'(er[2]), 0);
        send(2, 0);
        chk("ill.err1", int'(er[2]), 1);
        send(2, 7);
        send(2, 2);
        send(2, 2);
        chk("ill.hv_early", int'(hv[2]), 0);
        send(2, 5);
        chk("ill.hv", int'(hv[2]), 1);
        chk("ill.err_hold", int'(er[2]), 1);
        chk_cnt("ill", 2, 1, 2, 0, 0, 1, 0);
        hr[2] = 1'b1;
        clk1();
        chk("ill.err_clr", int'(er[2]), 0);
        hr[2] = 1'b0;

        // ---- asynchronous reset mid-frame
        for (int k = 0; k < 5; k++) send(3, 2);
        chk("rst.pre", int'(c[3][1]), 5);
        #3 rs[3] = 1'b1;                    // between clock edges
        #1;
        chk("rst.cnt2", int'(c[3][1]), 0);
        chk("rst.gr", int'(gr[3]), 1);
        chk("rst.hv", int'(hv[3]), 0);
        #2 rs[3] = 1'b0;
        clk1();
        chk("rst.gr_rel", int'(gr[3]), 1);
        for (int k = 0; k < 9; k++) send(3, 5);
        chk("rst.hv_9", int'(hv[3]), 0);
        send(3, 5);
        chk("rst.hv_10", int'(hv[3]), 1);
        chk_cnt("rst", 3, 0, 0, 0, 0, 10, 0);

        // ---- saturation at CNT_W=4
        for (int k = 0; k < 19; k++) send(4, 6);
        chk("sat.hv_early", int'(hv[4]), 0);
        chk("sat.mid", int'(c[4][5]), 15);
        send(4, 6);
        chk("sat.hv", int'(hv[4]), 1);
        chk_cnt("sat", 4, 0, 0, 0, 0, 0, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
